// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter time-sharing one 16-bit add/or/xor/and unit
//
// alu16: combinational 16-bit unit.
//   a, b  : operands            op  : 00 add, 01 or, 10 xor, 11 and
//   cin   : carry-in (add only) y   : result    co : carry-out (add only, else 0)
//
// alu_arbiter: accepts one operation at a time from requester 0 or 1, runs it
// through a single alu16 and presents the result with a valid/ready handshake.
//   clk, rst                    : clock, synchronous active-high reset
//   reqN_valid / reqN_ready     : request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op, reqN_cin : operation of requester N
//   rsp_valid / rsp_ready       : response handshake
//   rsp_id, rsp_data, rsp_co    : served requester, result, carry-out
//   ops_cnt                     : completed responses, wraps at 256
//
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; without it,
// requester 0 has fixed priority.

module alu16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  op,
    input  logic        cin,
    output logic [15:0] y,
    output logic        co
);
    logic [16:0] sum;

    assign sum = {1'b0, a} + {1'b0, b} + {16'd0, cin};

    always_comb begin
        y  = 16'h0000;
        co = 1'b0;
        case (op)
            2'b00: begin
                y  = sum[15:0];
                co = sum[16];
            end
            2'b01:   y = a | b;
            2'b10:   y = a ^ b;
            default: y = a & b;
        endcase
    end
endmodule

module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req0_cin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [1:0]  req1_op,
    input  logic        req1_cin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_co,
    output logic [7:0]  ops_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        acc_id;

    logic [15:0] cap_a;
    logic [15:0] cap_b;
    logic [1:0]  cap_op;
    logic        cap_cin;
    logic        cap_id;

    logic [15:0] alu_y;
    logic        alu_co;

    // Arbitration among valid requesters; a lone valid requester always wins.
`ifdef ALU_ARB_RR_EN
    // rr_ptr names the requester favoured on a tie; it flips away from
    // whoever was just accepted.
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~acc_id;
        end
    end

    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~rr_ptr);
        grant1 = req1_valid & (~req0_valid |  rr_ptr);
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
    end
`endif

    // Grants are mutually exclusive, so requester 1's ready identifies the winner.
    assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign acc_id = req1_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = EXEC;
            EXEC:                   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output logic; ready is also masked by rst so nothing is accepted
    // in a reset cycle.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0 & ~rst;
                req1_ready = grant1 & ~rst;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture: only the accept cycle matters, later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_a   <= 16'h0000;
            cap_b   <= 16'h0000;
            cap_op  <= 2'b00;
            cap_cin <= 1'b0;
            cap_id  <= 1'b0;
        end else if (accept) begin
            cap_a   <= acc_id ? req1_a   : req0_a;
            cap_b   <= acc_id ? req1_b   : req0_b;
            cap_op  <= acc_id ? req1_op  : req0_op;
            cap_cin <= acc_id ? req1_cin : req0_cin;
            cap_id  <= acc_id;
        end
    end

    alu16 u_alu (
        .a   (cap_a),
        .b   (cap_b),
        .op  (cap_op),
        .cin (cap_cin),
        .y   (alu_y),
        .co  (alu_co)
    );

    // Response registers load once in EXEC and hold through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= 16'h0000;
            rsp_co   <= 1'b0;
            rsp_id   <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data <= alu_y;
            rsp_co   <= alu_co;
            rsp_id   <= cap_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_cnt <= 8'd0;
        end else if (rsp_valid && rsp_ready) begin
            ops_cnt <= ops_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard testbench for alu_arbiter
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_cin;
    logic [15:0] req0_a, req0_b;
    logic [1:0]  req0_op;
    logic        req1_valid, req1_ready, req1_cin;
    logic [15:0] req1_a, req1_b;
    logic [1:0]  req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_co;
    logic [15:0] rsp_data;
    logic [7:0]  ops_cnt;

    typedef struct packed {
        logic        id;
        logic [15:0] data;
        logic        co;
    } rsp_t;

    rsp_t       sb[$];
    rsp_t       mon_e;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_co     (rsp_co),
        .ops_cnt    (ops_cnt)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op, input logic cin);
        logic [16:0] r;
        case (op)
            2'b00:   r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            2'b01:   r = {1'b0, a | b};
            2'b10:   r = {1'b0, a ^ b};
            default: r = {1'b0, a & b};
        endcase
        return r;
    endfunction

    // Monitor: every completed handshake must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got id %0d data 0x%0h, none expected", rsp_id, rsp_data);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", {31'd0, rsp_id}, {31'd0, mon_e.id});
                check("rsp_data", {16'd0, rsp_data}, {16'd0, mon_e.data});
                check("rsp_co", {31'd0, rsp_co}, {31'd0, mon_e.co});
            end
        end
    end

    task automatic set_req(input int id, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic [1:0] op, input logic cin);
        if (id == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_cin = cin;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_cin = cin;
        end
    endtask

    task automatic wait_accept(input int id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: requester %0d got no ready, expected ready within 20 cycles", id);
        end
    endtask

    // One operation with rsp_ready high: checks T+2 latency and ops_cnt.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic cin);
        logic [16:0] r;
        bit ok;
        r = model(a, b, op, cin);
        sb.push_back('{id: id[0], data: r[15:0], co: r[16]});
        set_req(id, 1'b1, a, b, op, cin);
        wait_accept(id, ok);
        if (!ok) begin
            set_req(id, 1'b0, a, b, op, cin);
            void'(sb.pop_back());
            return;
        end
        check("other_ready", {31'd0, (id == 0) ? req1_ready : req0_ready}, 32'd0);
        @(posedge clk); #1;
        set_req(id, 1'b0, 16'hDEAD, 16'hBEEF, ~op, ~cin);
        @(negedge clk);
        check("lat_exec_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("lat_resp_valid", {31'd0, rsp_valid}, 32'd1);
        exp_cnt = exp_cnt + 8'd1;
        @(posedge clk); #1;
        check("ops_cnt", {24'd0, ops_cnt}, {24'd0, exp_cnt});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 8'd0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        logic [15:0] wa, wb;
        rst = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 16'h0, 16'h0, 2'b00, 1'b0);
        set_req(1, 1'b1, 16'h0, 16'h0, 2'b00, 1'b0);

        // Reset values; no ready while rst is high even with both valid.
        @(negedge clk);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("rst_rsp_co", {31'd0, rsp_co}, 32'd0);
        check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("rst_ops_cnt", {24'd0, ops_cnt}, 32'd0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready0", {31'd0, req0_ready}, 32'd0);
        check("idle_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;

        // Directed vectors
        issue(0, 16'h7FFF, 16'h0001, 2'b00, 1'b0);   // 8000, co 0
        issue(1, 16'hFFFF, 16'h0001, 2'b00, 1'b0);   // 0000, co 1
        issue(1, 16'hFFFF, 16'h00FF, 2'b11, 1'b1);   // 00FF, co 0
        issue(0, 16'h1234, 16'h0F0F, 2'b01, 1'b1);   // 1F3F, co 0
        issue(1, 16'hAAAA, 16'hFFFF, 2'b10, 1'b0);   // 5555
        issue(0, 16'hFFFF, 16'hFFFF, 2'b00, 1'b1);   // FFFF, co 1
        issue(1, 16'h0000, 16'h0000, 2'b00, 1'b1);   // 0001, co 0

        // Back-pressure: response held, inputs changed and asserted meanwhile.
        rsp_ready = 1'b0;
        sb.push_back('{id: 1'b0, data: 16'h0003, co: 1'b0});
        set_req(0, 1'b1, 16'h0001, 16'h0002, 2'b00, 1'b0);
        wait_accept(0, ok);
        @(posedge clk); #1;
        set_req(0, 1'b1, 16'hFFFF, 16'hFFFF, 2'b00, 1'b1);
        set_req(1, 1'b1, 16'h5555, 16'h1111, 2'b01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_data", {16'd0, rsp_data}, 32'h0003);
            check("stall_co", {31'd0, rsp_co}, 32'd0);
            check("stall_id", {31'd0, rsp_id}, 32'd0);
            check("stall_ready0", {31'd0, req0_ready}, 32'd0);
            check("stall_ready1", {31'd0, req1_ready}, 32'd0);
            check("stall_ops_cnt", {24'd0, ops_cnt}, {24'd0, exp_cnt});
            @(negedge clk);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        rsp_ready = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        @(posedge clk); #1;
        check("stall_ops_cnt_after", {24'd0, ops_cnt}, {24'd0, exp_cnt});

        // Both valid continuously from reset.
        rst = 1'b1;
        set_req(0, 1'b1, 16'h0100, 16'h0001, 2'b00, 1'b0);
        set_req(1, 1'b1, 16'h0200, 16'h0002, 2'b00, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 8'd0;
`ifdef ALU_ARB_RR_EN
        sb.push_back('{id: 1'b0, data: 16'h0101, co: 1'b0});
        sb.push_back('{id: 1'b1, data: 16'h0202, co: 1'b0});
        sb.push_back('{id: 1'b0, data: 16'h0101, co: 1'b0});
        sb.push_back('{id: 1'b1, data: 16'h0202, co: 1'b0});
`else
        for (int i = 0; i < 4; i++) sb.push_back('{id: 1'b0, data: 16'h0101, co: 1'b0});
`endif
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL arb_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        exp_cnt = 8'd4;
        check("arb_ops_cnt", {24'd0, ops_cnt}, {24'd0, exp_cnt});
        @(posedge clk); #1;

        // Reset in EXEC discards the operation.
        set_req(1, 1'b1, 16'h1111, 16'h2222, 2'b00, 1'b0);
        wait_accept(1, ok);
        @(posedge clk); #1;
        set_req(1, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 8'd0;
        @(negedge clk);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_ops_cnt", {24'd0, ops_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // 256 responses from reset wrap ops_cnt to zero.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            wa = 16'(i * 291 + 32768);
            wb = 16'(i * 4369);
            issue(i[3] ? 1 : 0, wa, wb, i[1:0], i[2]);
            if (i == 254) check("ops_cnt_255", {24'd0, ops_cnt}, 32'hFF);
        end
        check("ops_cnt_wrap", {24'd0, ops_cnt}, 32'h00);
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
